// File: rtl/s3g_uart_tx.sv
// 8N1/8N2 UART transmitter closing the tx_wr/tx_done handshake of s3g_tx.
// One frame per accepted strobe; tx_done coincides with the final stop-bit cycle.
module s3g_uart_tx #(
  parameter int CLK_DIV   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       busy,
  output logic       txd,
  output logic       overrun
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (tx_wr && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (tx_wr) begin
          shift_d = tx_data;
          cnt_d   = CNT_LOAD;
          bit_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        // Final stop cycle is spent in IDLE with tx_done high, so leave one count early.
        if ((bit_q == LAST_STOP) && (cnt_q == CNT_ONE)) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign txd     = txd_q;
  assign tx_done = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_s3g_uart_tx.sv
// Scoreboard bench for s3g_uart_tx: unit 0 runs CLK_DIV=4/1 stop, unit 1 CLK_DIV=3/2 stop.
// Stimulus pushes expected bytes; a negedge monitor decodes txd and compares each frame.
module tb_s3g_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] wr_v = 2'b00;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic [1:0] done_v, busy_v, txd_v, ovr_v;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int acc_base [2];
  int done_cnt [2];

  logic [7:0] exp_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  s3g_uart_tx #(.CLK_DIV(4), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_wr(wr_v[0]), .tx_data(data0),
    .tx_done(done_v[0]), .busy(busy_v[0]), .txd(txd_v[0]), .overrun(ovr_v[0])
  );

  s3g_uart_tx #(.CLK_DIV(3), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_wr(wr_v[1]), .tx_data(data1),
    .tx_done(done_v[1]), .busy(busy_v[1]), .txd(txd_v[1]), .overrun(ovr_v[1])
  );

  function automatic int div_of(int u);
    return (u == 0) ? 4 : 3;
  endfunction

  function automatic int frame_of(int u);
    return (u == 0) ? 40 : 33;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_cnt, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit         act_f [2];
  int         c_f   [2];
  int         werr  [2];
  logic [7:0] cur   [2];
  logic [7:0] dec   [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int d, f, b, off;
      logic exp_txd;
      d = div_of(u);
      f = frame_of(u);
      if (rst) begin
        act_f[u] = 1'b0;
        exp_q[u].delete();
      end else begin
        if (done_v[u]) done_cnt[u]++;
        if (!act_f[u]) begin
          if (txd_v[u] === 1'b0) begin
            check("frame_expected", 32'(exp_q[u].size() > 0), 32'd1);
            cur[u]   = (exp_q[u].size() > 0) ? exp_q[u].pop_front() : 8'h00;
            act_f[u] = 1'b1;
            c_f[u]   = 0;
            werr[u]  = 0;
            dec[u]   = 8'h00;
          end else begin
            check("idle_busy_done", {30'd0, busy_v[u], done_v[u]}, 32'd0);
          end
        end
        if (act_f[u]) begin
          c_f[u]++;
          b   = (c_f[u] - 1) / d;
          off = (c_f[u] - 1) % d;
          if (b == 0)      exp_txd = 1'b0;
          else if (b <= 8) exp_txd = cur[u][b-1];
          else             exp_txd = 1'b1;
          if (txd_v[u] !== exp_txd || busy_v[u] !== (c_f[u] < f) ||
              done_v[u] !== (c_f[u] == f))
            werr[u]++;
          if (off == d / 2 && b >= 1 && b <= 8) dec[u][b-1] = txd_v[u];
          if (c_f[u] == f) begin
            check("frame_byte", 32'(dec[u]), 32'(cur[u]));
            check("frame_wave_errs", 32'(werr[u]), 32'd0);
            act_f[u] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(int u, logic w, logic [7:0] b);
    if (u == 0) begin wr_v[0] = w; data0 = b; end
    else        begin wr_v[1] = w; data1 = b; end
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(int u, logic [7:0] b, bit accept);
    set_in(u, 1'b1, b);
    if (accept) begin
      acc_base[u] = cyc_cnt;
      exp_q[u].push_back(b);
    end
    step(1);
    set_in(u, 1'b0, ~b);
    if (accept) check("start_latency", {30'd0, txd_v[u], busy_v[u]}, 32'b01);
  endtask

  task automatic wait_done(int u);
    int guard = 0;
    while (done_v[u] !== 1'b1 && guard < 200) begin
      step(1);
      guard++;
    end
    check("done_latency", 32'(cyc_cnt - acc_base[u]), 32'(frame_of(u)));
  endtask

  task automatic check_idle_regs(int u, logic ovr_exp);
    check("idle_txd", 32'(txd_v[u]), 32'd1);
    check("idle_busy", 32'(busy_v[u]), 32'd0);
    check("idle_done", 32'(done_v[u]), 32'd0);
    check("overrun", 32'(ovr_v[u]), 32'(ovr_exp));
  endtask

  initial begin
    logic [7:0] pkt [6];
    int snap;
    pkt = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    done_cnt[0] = 0;
    done_cnt[1] = 0;

    // reset and idle
    step(2);
    rst = 1'b0;
    check_idle_regs(0, 1'b0);
    check_idle_regs(1, 1'b0);
    step(50);
    check_idle_regs(0, 1'b0);
    check("no_done_idle", 32'(done_cnt[0]), 32'd0);

    // single frame 0xD5
    issue(0, 8'hD5, 1'b1);
    wait_done(0);
    step(5);

    // back-to-back packet, each tx_wr on the tx_done cycle
    issue(0, pkt[0], 1'b1);
    for (int i = 1; i < 6; i++) begin
      wait_done(0);
      issue(0, pkt[i], 1'b1);
    end
    wait_done(0);
    step(5);
    check("overrun_after_packet", 32'(ovr_v[0]), 32'd0);
    check("done_count_packet", 32'(done_cnt[0]), 32'd7);

    // overrun: second strobe while busy is ignored
    snap = done_cnt[0];
    issue(0, 8'h55, 1'b1);
    step(9);
    issue(0, 8'hAA, 1'b0);
    wait_done(0);
    step(20);
    check("overrun_set", 32'(ovr_v[0]), 32'd1);
    check("overrun_one_done", 32'(done_cnt[0] - snap), 32'd1);

    // reset mid-frame aborts without tx_done
    snap = done_cnt[0];
    issue(0, 8'h0F, 1'b1);
    step(14);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_idle_regs(0, 1'b0);
    step(50);
    check("abort_no_done", 32'(done_cnt[0] - snap), 32'd0);
    issue(0, 8'hCC, 1'b1);
    wait_done(0);
    step(5);

    // two stop bits, CLK_DIV=3
    issue(1, 8'h00, 1'b1);
    wait_done(1);
    step(5);
    check("done_count_u1", 32'(done_cnt[1]), 32'd1);

    check("queue_drained_u0", 32'(exp_q[0].size()), 32'd0);
    check("queue_drained_u1", 32'(exp_q[1].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/s3g_uart_tx.md
Name: s3g_uart_tx

Overview:
- Serial byte transmitter that sits downstream of s3g_tx.
- Consumes the tx_wr/tx_data strobe and returns tx_done once the byte has fully left the pin.
- Serialises each byte as 8N1 (or 8N2) asynchronous UART, LSB first, at a fixed integer clock divisor.
- Closes the tx_wr/tx_done handshake that s3g_tx relies on. It is the counterpart of the serial receiver feeding s3g_rx.

Parameters:
- CLK_DIV, 16, clock cycles per bit period; legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tx_wr  input  1  one-cycle strobe: tx_data valid, start a frame
- tx_data  input  8  byte to send; sampled only in the cycle tx_wr is accepted
- tx_done  output  1  one-cycle pulse: last stop bit completed
- busy  output  1  high from the cycle after acceptance until the cycle tx_done pulses
- txd  output  1  serial line; idle high
- overrun  output  1  sticky: tx_wr seen while busy; cleared only by rst

Behaviour:
- Reset (rst=1 at a clock edge):
  - txd=1, busy=0, tx_done=0, overrun=0, state=IDLE.
  - Bit counter, divisor counter and shift register cleared.
  - Reset mid-frame aborts immediately: txd returns high on the next edge, no tx_done is issued.
- States:
  - IDLE: txd=1, busy=0. tx_wr=1 latches tx_data into the shift register, loads the divisor counter with CLK_DIV-1, and moves to START.
  - START: txd=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: txd=shift[0] for CLK_DIV cycles per bit, shifting right after each bit. After bit 7 it moves to STOP.
  - STOP: txd=1 for STOP_BITS*CLK_DIV cycles, then IDLE with tx_done=1 for exactly one cycle.
- Timing:
  - txd drives the start bit in the cycle immediately after the tx_wr acceptance edge.
  - busy asserts in that same cycle.
  - tx_done pulses (1+8+STOP_BITS)*CLK_DIV cycles after the acceptance edge.
  - busy=0 in the tx_done cycle.
- Back-to-back: tx_wr in the same cycle tx_done is high is accepted (state is IDLE). The next start bit follows the last stop bit with no idle gap.
- Overrun: tx_wr while busy=1 is ignored. The frame in flight is unaffected, and overrun is set and held.
- tx_data changing after acceptance has no effect on the frame in flight.
- Divisor counter width: ceil(log2(CLK_DIV)), minimum 1 bit; no wrap-around is observable.
- tx_done is never asserted without a preceding accepted tx_wr.

Test Plan:
- Reset then idle 50 cycles, CLK_DIV=4 -> txd=1, busy=0, tx_done=0, overrun=0 throughout.
- CLK_DIV=4, tx_wr with tx_data=0xD5 -> txd bit periods are 0, 1,0,1,0,1,0,1,1, 1 (4 cycles each). tx_done pulses exactly 40 cycles after the accept edge. busy is high for cycles 1..39.
- Send the full packet D5 03 01 02 03 D8, issuing each tx_wr on its tx_done pulse -> continuous 10-bit frames with no gap. Bench UART model decodes the identical 6 bytes. overrun stays 0.
- tx_wr 0x55 accepted, then tx_wr 0xAA with 0xAA on tx_data 10 cycles later -> frame still carries 0x55, overrun=1, exactly one tx_done pulse.
- STOP_BITS=2, CLK_DIV=3, byte 0x00 -> txd low for 27 cycles, then high for 6. tx_done at cycle 33.
- rst asserted at cycle 15 of a 0x0F frame -> next edge txd=1, busy=0, no tx_done. A subsequent tx_wr 0xCC transmits correctly.
